// File: rtl/rbfu_lane_array.sv
// Lane-parallel modular butterfly over Z_Q: CT-NTT, GS-INTT, pointwise multiply, bypass.
// 3-cycle latency at 1 beat/cycle; all stages freeze together while out_valid waits on out_ready.
module rbfu_lane_array #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int TAG_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  opcode,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic [LANES*DATA_WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [LANES*DATA_WIDTH-1:0] out_x0,
  output logic [LANES*DATA_WIDTH-1:0] out_x1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_tag,
  output logic [15:0]                 beat_cnt,
  output logic                        err
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int BW = 2 * PW + 1;
  localparam logic [BW-1:0] BM = BW'((64'd1 << PW) / 64'(Q));
  localparam logic [BW-1:0] QB = BW'(Q);
  localparam logic [DW-1:0] QD = DW'(Q);

  typedef enum logic [1:0] {
    OP_CT  = 2'b00,
    OP_GS  = 2'b01,
    OP_PWM = 2'b10,
    OP_BYP = 2'b11
  } op_e;

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QD}) s = s - {1'b0, QD};
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + {1'b0, QD} - {1'b0, y};
    return DW'(d);
  endfunction

  // Barrett reduction of a product < 2^PW; the quotient estimate is at most 2 low.
  function automatic logic [DW-1:0] mod_red(input logic [PW-1:0] x);
    logic [BW-1:0] xe, qt, r;
    xe = BW'(x);
    qt = (xe * BM) >> PW;
    r  = xe - qt * QB;
    if (r >= QB) r = r - QB;
    if (r >= QB) r = r - QB;
    return DW'(r);
  endfunction

  logic          w_en;
  logic          w_take;
  logic          w_range_err;
  op_e           w_op;
  logic [DW-1:0] w_a   [LANES];
  logic [DW-1:0] w_b   [LANES];
  logic [DW-1:0] w_w   [LANES];
  logic [DW-1:0] w_p   [LANES];
  logic [DW-1:0] w_m0a [LANES];
  logic [DW-1:0] w_m0b [LANES];
  logic [DW-1:0] w_m1a [LANES];
  logic [DW-1:0] w_m1b [LANES];
  logic [DW-1:0] w_t0  [LANES];
  logic [DW-1:0] w_t1  [LANES];
  logic [LANES*DW-1:0] w_x0, w_x1;

  logic             r1_vld, r2_vld;
  op_e              r1_op, r2_op;
  logic [TAG_W-1:0] r1_tag, r2_tag;
  logic [DW-1:0]    r1_p   [LANES];
  logic [DW-1:0]    r1_m0a [LANES];
  logic [DW-1:0]    r1_m0b [LANES];
  logic [DW-1:0]    r1_m1a [LANES];
  logic [DW-1:0]    r1_m1b [LANES];
  logic [DW-1:0]    r2_p   [LANES];
  logic [DW-1:0]    r2_aux [LANES];
  logic [PW-1:0]    r2_prod0 [LANES];
  logic [PW-1:0]    r2_prod1 [LANES];

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_take   = in_valid && w_en;
  assign w_op     = op_e'(opcode);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_a[g]  = in_a[g*DW +: DW];
    assign w_b[g]  = in_b[g*DW +: DW];
    assign w_w[g]  = in_w[g*DW +: DW];
    assign w_t0[g] = mod_red(r2_prod0[g]);
    assign w_t1[g] = mod_red(r2_prod1[g]);
  end

  // S1: pre-add/sub and steer each lane's operands onto two multipliers plus a pass-through.
  always_comb begin
    w_range_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_p[i]   = w_a[i];
      w_m0a[i] = '0;
      w_m0b[i] = '0;
      w_m1a[i] = '0;
      w_m1b[i] = '0;
      if (w_a[i] >= QD || w_b[i] >= QD || w_w[i] >= QD) w_range_err = 1'b1;
      case (w_op)
        OP_CT: begin
          w_m0a[i] = w_w[i];
          w_m0b[i] = w_b[i];
        end
        OP_GS: begin
          w_p[i]   = mod_add(w_a[i], w_b[i]);
          w_m0a[i] = mod_sub(w_a[i], w_b[i]);
          w_m0b[i] = w_w[i];
        end
        OP_PWM: begin
          w_m0a[i] = w_a[i];
          w_m0b[i] = w_b[i];
          w_m1a[i] = w_a[i];
          w_m1b[i] = w_w[i];
        end
        default: w_m0a[i] = w_b[i];
      endcase
    end
  end

  // S1/S2 datapath registers; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_op  <= w_op;
      r1_tag <= in_tag;
      r2_op  <= r1_op;
      r2_tag <= r1_tag;
      for (int i = 0; i < LANES; i++) begin
        r1_p[i]     <= w_p[i];
        r1_m0a[i]   <= w_m0a[i];
        r1_m0b[i]   <= w_m0b[i];
        r1_m1a[i]   <= w_m1a[i];
        r1_m1b[i]   <= w_m1b[i];
        r2_p[i]     <= r1_p[i];
        r2_aux[i]   <= r1_m0a[i];
        r2_prod0[i] <= PW'(r1_m0a[i]) * PW'(r1_m0b[i]);
        r2_prod1[i] <= PW'(r1_m1a[i]) * PW'(r1_m1b[i]);
      end
    end
  end

  // S3: post-add/sub on the reduced products.
  always_comb begin
    w_x0 = '0;
    w_x1 = '0;
    for (int i = 0; i < LANES; i++) begin
      case (r2_op)
        OP_CT: begin
          w_x0[i*DW +: DW] = mod_add(r2_p[i], w_t0[i]);
          w_x1[i*DW +: DW] = mod_sub(r2_p[i], w_t0[i]);
        end
        OP_GS: begin
          w_x0[i*DW +: DW] = r2_p[i];
          w_x1[i*DW +: DW] = w_t0[i];
        end
        OP_PWM: begin
          w_x0[i*DW +: DW] = w_t0[i];
          w_x1[i*DW +: DW] = w_t1[i];
        end
        default: begin
          w_x0[i*DW +: DW] = r2_p[i];
          w_x1[i*DW +: DW] = r2_aux[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld    <= 1'b0;
      r2_vld    <= 1'b0;
      out_valid <= 1'b0;
      out_x0    <= '0;
      out_x1    <= '0;
      out_tag   <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
      if (w_take && (w_range_err || w_op == OP_BYP)) err <= 1'b1;
      if (w_en) begin
        r1_vld    <= in_valid;
        r2_vld    <= r1_vld;
        out_valid <= r2_vld;
        out_x0    <= w_x0;
        out_x1    <= w_x1;
        out_tag   <= r2_tag;
      end
    end
  end

endmodule

// File: tb/tb_rbfu_lane_array.sv
// Bench for rbfu_lane_array: directed table, stall/reset sequences, and a random
// stream compared against a mod-Q reference model on 1-, 4- and 8-lane instances.
module tb_rbfu_lane_array;

  localparam int DW   = 12;
  localparam int QM   = 3329;
  localparam int TW   = 8;
  localparam int LMAX = 8;
  localparam int NV   = 10;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [1:0] opcode;
  logic [LMAX*DW-1:0] in_a, in_b, in_w;
  logic [TW-1:0] in_tag;
  logic out_ready;

  logic in_ready_1, in_ready_4, in_ready_8;
  logic out_valid_1, out_valid_4, out_valid_8;
  logic [DW-1:0]   out_x0_1, out_x1_1;
  logic [4*DW-1:0] out_x0_4, out_x1_4;
  logic [8*DW-1:0] out_x0_8, out_x1_8;
  logic [TW-1:0]   out_tag_1, out_tag_4, out_tag_8;
  logic [15:0]     beat_cnt_1, beat_cnt_4, beat_cnt_8;
  logic            err_1, err_4, err_8;

  always #5 clk = ~clk;

  rbfu_lane_array #(.LANES(4), .DATA_WIDTH(DW), .Q(QM), .TAG_W(TW)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4), .opcode(opcode),
    .in_a(in_a[4*DW-1:0]), .in_b(in_b[4*DW-1:0]), .in_w(in_w[4*DW-1:0]), .in_tag(in_tag),
    .out_x0(out_x0_4), .out_x1(out_x1_4), .out_valid(out_valid_4), .out_ready(out_ready),
    .out_tag(out_tag_4), .beat_cnt(beat_cnt_4), .err(err_4));

  rbfu_lane_array #(.LANES(1), .DATA_WIDTH(DW), .Q(QM), .TAG_W(TW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .opcode(opcode),
    .in_a(in_a[DW-1:0]), .in_b(in_b[DW-1:0]), .in_w(in_w[DW-1:0]), .in_tag(in_tag),
    .out_x0(out_x0_1), .out_x1(out_x1_1), .out_valid(out_valid_1), .out_ready(out_ready),
    .out_tag(out_tag_1), .beat_cnt(beat_cnt_1), .err(err_1));

  rbfu_lane_array #(.LANES(8), .DATA_WIDTH(DW), .Q(QM), .TAG_W(TW)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8), .opcode(opcode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
    .out_x0(out_x0_8), .out_x1(out_x1_8), .out_valid(out_valid_8), .out_ready(out_ready),
    .out_tag(out_tag_8), .beat_cnt(beat_cnt_8), .err(err_8));

  typedef struct {
    int op;
    int a, b, w;
    int x0, x1;
  } vec_t;

  typedef struct {
    logic [LMAX*DW-1:0] x0, x1;
    logic [TW-1:0]      tag;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int lat, sent, got, stale, delivered, accepted, cyc;
  bit err_exp, stall_prev;
  logic [LMAX*DW-1:0] tmp0, tmp1, held_x0;
  logic [TW-1:0] held_tag;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Plain modular arithmetic straight from the butterfly definitions.
  function automatic void model(input int op, input int a, input int b, input int w,
                                output int x0, output int x1);
    longint t, d;
    case (op)
      0: begin
        t  = (longint'(w) * b) % QM;
        x0 = int'((a + t) % QM);
        x1 = int'((a - t + QM) % QM);
      end
      1: begin
        x0 = (a + b) % QM;
        d  = ((longint'(a) - b) % QM + QM) % QM;
        x1 = int'((d * w) % QM);
      end
      2: begin
        x0 = int'((longint'(a) * b) % QM);
        x1 = int'((longint'(a) * w) % QM);
      end
      default: begin
        x0 = a;
        x1 = b;
      end
    endcase
  endfunction

  function automatic exp_t predict(input int op, input logic [LMAX*DW-1:0] a,
                                   input logic [LMAX*DW-1:0] b, input logic [LMAX*DW-1:0] w,
                                   input logic [TW-1:0] tag);
    exp_t r;
    int x0, x1;
    r.tag = tag;
    r.x0  = '0;
    r.x1  = '0;
    for (int l = 0; l < LMAX; l++) begin
      model(op, int'(a[l*DW +: DW]), int'(b[l*DW +: DW]), int'(w[l*DW +: DW]), x0, x1);
      r.x0[l*DW +: DW] = DW'(x0);
      r.x1[l*DW +: DW] = DW'(x1);
    end
    return r;
  endfunction

  function automatic logic [LMAX*DW-1:0] rep8(input int v);
    logic [LMAX*DW-1:0] r;
    for (int l = 0; l < LMAX; l++) r[l*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_opnd();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return DW'(QM - 1);
    return DW'($urandom_range(0, QM - 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = '0; in_tag = '0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_w = '0;
    vt[0] = '{0, 5, 7, 17, 124, 3215};
    vt[1] = '{1, 10, 20, 2, 30, 3309};
    vt[2] = '{2, 3328, 3328, 2, 1, 3327};
    vt[3] = '{0, 0, 3328, 3328, 1, 3328};
    vt[4] = '{0, 3328, 1, 1, 0, 3327};
    vt[5] = '{1, 0, 0, 3328, 0, 0};
    vt[6] = '{1, 0, 1, 1, 1, 3328};
    vt[7] = '{2, 0, 5, 6, 0, 0};
    vt[8] = '{3, 9, 4, 0, 9, 4};
    vt[9] = '{0, 1000, 2000, 3000, 2142, 3187};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid_4, 0);
    chk("rst_beat_cnt", beat_cnt_4, 0);
    chk("rst_err", err_4, 0);
    chk("rst_out_x0", out_x0_4, 0);
    chk("rst_out_tag", out_tag_4, 0);
    chk("rst_in_ready", in_ready_4, 1);

    // Directed table, one isolated beat per vector, identical across lanes.
    err_exp = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      opcode = 2'(vt[i].op);
      in_a = rep8(vt[i].a); in_b = rep8(vt[i].b); in_w = rep8(vt[i].w);
      in_tag = TW'(i + 8'h40);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid_4 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      tmp0 = rep8(vt[i].x0);
      tmp1 = rep8(vt[i].x1);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_x0", i), out_x0_4, tmp0[4*DW-1:0]);
      chk($sformatf("vec%0d_x1", i), out_x1_4, tmp1[4*DW-1:0]);
      chk($sformatf("vec%0d_tag", i), out_tag_4, i + 8'h40);
      if (vt[i].op == 3) err_exp = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), out_valid_4, 0);
      chk($sformatf("vec%0d_err", i), err_4, err_exp);
    end

    // Back-to-back stream of 8 beats with a 3-cycle output stall.
    do_reset();
    sent = 0; got = 0; stall_prev = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid = (sent < 8);
      opcode = 2'd0;
      in_a = rep8(sent); in_b = rep8(1); in_w = rep8(1);
      in_tag = TW'(sent);
      #1;
      if (stall_prev) begin
        chk("stall_hold_x0", out_x0_4, held_x0[4*DW-1:0]);
        chk("stall_hold_tag", out_tag_4, held_tag);
        chk("stall_hold_valid", out_valid_4, 1);
      end
      stall_prev = out_valid_4 && !out_ready;
      held_x0 = '0;
      held_x0[4*DW-1:0] = out_x0_4;
      held_tag = out_tag_4;
      if (out_valid_4 && out_ready) begin
        tmp0 = rep8(got + 1);
        tmp1 = rep8((got + QM - 1) % QM);
        chk("stream_tag", out_tag_4, got);
        chk("stream_x0", out_x0_4, tmp0[4*DW-1:0]);
        chk("stream_x1", out_x1_4, tmp1[4*DW-1:0]);
        got++;
      end
      if (in_valid && in_ready_4) sent++;
    end
    chk("stream_delivered", got, 8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_beat_cnt", beat_cnt_4, 8);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_4) stale++;
    end
    chk("stream_no_dup", stale, 0);

    // Two beats in flight, the first carrying an out-of-range operand, then reset.
    @(negedge clk);
    opcode = 2'd0; in_valid = 1'b1;
    in_a = rep8(1); in_b = rep8(QM); in_w = rep8(1); in_tag = 8'hA0;
    @(negedge clk);
    in_b = rep8(2); in_tag = 8'hA1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("range_err", err_4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_4, 0);
    chk("midrst_beat_cnt", beat_cnt_4, 0);
    chk("midrst_err", err_4, 0);
    chk("midrst_out_x0", out_x0_4, 0);
    chk("midrst_in_ready", in_ready_4, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_4) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    // Random stream on all three lane counts against the reference model.
    do_reset();
    sb.delete();
    delivered = 0; accepted = 0; cyc = 0;
    while (delivered < 2000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      in_valid = (accepted < 2000) && ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      opcode = 2'($urandom_range(0, 3));
      in_tag = TW'($urandom);
      for (int l = 0; l < LMAX; l++) begin
        in_a[l*DW +: DW] = rnd_opnd();
        in_b[l*DW +: DW] = rnd_opnd();
        in_w[l*DW +: DW] = rnd_opnd();
      end
      #1;
      if (out_valid_4 && out_ready) begin
        chk("rand_sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rand_l4_x0", out_x0_4, e.x0[4*DW-1:0]);
          chk("rand_l4_x1", out_x1_4, e.x1[4*DW-1:0]);
          chk("rand_l4_tag", out_tag_4, e.tag);
          chk("rand_l1_x", {out_x0_1, out_x1_1, out_tag_1}, {e.x0[DW-1:0], e.x1[DW-1:0], e.tag});
          chk("rand_l8_x0", out_x0_8, e.x0);
          chk("rand_l8_x1", out_x1_8, e.x1);
          chk("rand_l8_tag", out_tag_8, e.tag);
          chk("rand_handshake", {out_valid_1, out_valid_8, in_ready_1, in_ready_8},
              {2'b11, in_ready_4, in_ready_4});
        end
        delivered++;
      end
      if (in_valid && in_ready_4) begin
        sb.push_back(predict(int'(opcode), in_a, in_b, in_w, in_tag));
        accepted++;
      end
    end
    chk("rand_delivered", delivered, 2000);
    chk("rand_sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("rand_beat_cnt", {beat_cnt_1, beat_cnt_4, beat_cnt_8}, {16'd2000, 16'd2000, 16'd2000});
    chk("rand_err_sticky", {err_1, err_4, err_8}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
